rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one resource between up to 2**NUMW requesters.
- Samples a request bitmap and issues a registered one-hot grant plus its encoded index (bitmap-to-number, same encoding as the shared encoder macro).
- Holds the grant until the owner releases it or a hold timeout expires, then advances the priority pointer.
- Sits between requesting engines and a shared datapath/bus port; gnt_num drives the datapath mux select directly.

Parameters:
- NUMW, 4, width of the encoded grant index.
- NREQ, 2**NUMW, number of requesters (bitmap width).
- HOLDW, 8, width of the hold counter.
- HOLDMAX, 255, maximum grant cycles per owner; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  arbitration enable; 0 blocks new grants and revokes the current one.
- req  input  NREQ  request bitmap; bit i = requester i wants the resource.
- done  input  1  owner release strobe, sampled only in GRANT.
- gnt  output  NREQ  registered one-hot grant; all zero when idle.
- gnt_num  output  NUMW  index of the set bit of gnt; 0 when gnt is zero.
- gnt_vld  output  1  1 while any grant is held (equals OR of gnt).
- tmo  output  1  one-cycle pulse: grant was revoked by hold timeout.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, gnt_num=0, gnt_vld=0, tmo=0.
  - state=IDLE, hold_cnt=0, last=NREQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, GRANT.
- IDLE:
  - If ena=1 and req!=0: winner = first set req bit scanning last+1, last+2, ... with modulo-NREQ wrap.
  - Next cycle: gnt=onehot(winner), gnt_num=winner, gnt_vld=1, hold_cnt=0, state=GRANT.
  - Latency: req sampled in cycle N, grant visible in cycle N+1.
  - Otherwise stay in IDLE with outputs at zero.
- GRANT release, evaluated each cycle:
  - Release when done=1, OR req[owner]=0, OR ena=0, OR (HOLDMAX!=0 and hold_cnt==HOLDMAX-1).
  - On release: next cycle gnt=0, gnt_num=0, gnt_vld=0, last=owner, state=IDLE.
  - If no release: hold_cnt increments; it saturates and never wraps.
- Timeout release gives exactly HOLDMAX grant cycles.
  - tmo=1 in the first IDLE cycle, only when the timeout was the sole release cause.
  - If done=1 in the same cycle, done wins and tmo=0.
- Mandatory gap: at least one IDLE cycle (gnt=0) between consecutive grants, including re-grant to the same requester. This is the resource turnaround slot.
- Requests arriving or changing while in GRANT have no effect on the current owner.
- Single requester repeatedly requesting: it is re-granted after each gap (no starvation, no lockout).
- All requesters asserting: grant order is last+1, last+2, ... wrapping from NREQ-1 to 0.
- req=0 in IDLE with ena=1: no grant, and last is unchanged.
- Reset asserted mid-GRANT: outputs clear immediately (asynchronous); the pointer returns to NREQ-1.
- Invariant: gnt is always one-hot or zero; gnt_num is consistent with gnt in the same cycle.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=1'b0, GRANT=1'b1.
  - Default NUMW/HOLDW/HOLDMAX constants.
- One combinational sub-module, rr_pick:
  - Inputs: req, last. Outputs: winner index and a found flag.
  - Implementation: req rotated right by last+1, then lowest-set-bit priority encode, then index re-add modulo NREQ.
- The top level holds the FSM, hold counter, pointer and output registers.

Test Plan (NUMW=2, NREQ=4, HOLDMAX=4):
1. Reset, then ena=1, req=4'b1111 held, done pulsed 1 cycle in each grant -> gnt_num sequence 0,1,2,3,0. Each grant arrives one cycle after IDLE and is separated by exactly one gnt=0 cycle.
2. req=4'b0100 held, no done -> gnt=4'b0100 for exactly 4 cycles, then gnt=0 with tmo=1 for 1 cycle, then re-granted to 2 on the next cycle.
3. Owner 1 granted, req changes to 4'b1001 -> gnt drops the next cycle. Next grant goes to 3 (pointer was 1), then 0.
4. Owner 2 granted, ena=0 for one cycle -> gnt=0 and gnt_vld=0 the next cycle, tmo=0. No new grant while ena=0; with ena back to 1 and req=4'b0100, 2 is re-granted.
5. rst_n pulsed low mid-GRANT (owner 3) -> gnt/gnt_num/gnt_vld zero immediately, no clock edge needed. After release with req=4'b1010, first grant goes to 1.
6. done=1 in the same cycle hold_cnt reaches 3 -> gnt drops the next cycle with tmo=0.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding
// and default sizing constants.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_NUMW    = 4;
  localparam int DEF_HOLDW   = 8;
  localparam int DEF_HOLDMAX = 255;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request bit at or after last+1,
// wrapping modulo NREQ.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int NUMW = DEF_NUMW,
  parameter int NREQ = 2**NUMW
) (
  input  logic [NREQ-1:0] req,
  input  logic [NUMW-1:0] last,
  output logic [NUMW-1:0] winner,
  output logic            found
);

  logic [NUMW-1:0] start;
  logic [NREQ-1:0] rotated;
  logic [NUMW-1:0] offset;

  assign start = last + 1'b1;

  // Index arithmetic is NUMW bits wide, so it wraps modulo NREQ by itself.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NREQ; i++) begin
      rotated[i] = req[NUMW'(i) + start];
    end
  end

  always_comb begin
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = NUMW'(i);
      end
    end
  end

  assign winner = start + offset;
  assign found  = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant with encoded index, hold
// timeout, and a mandatory idle turnaround cycle between grants.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int NUMW    = DEF_NUMW,
  parameter int NREQ    = 2**NUMW,
  parameter int HOLDW   = DEF_HOLDW,
  parameter int HOLDMAX = DEF_HOLDMAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [NUMW-1:0] gnt_num,
  output logic            gnt_vld,
  output logic            tmo
);

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'((HOLDMAX > 0) ? HOLDMAX - 1 : 0);
  localparam bit               TMO_EN    = (HOLDMAX != 0);

  state_t          state;
  logic [HOLDW-1:0] hold_cnt;
  logic [NUMW-1:0] last;
  logic [NUMW-1:0] winner;
  logic            found;
  logic            owner_req;
  logic            hold_hit;
  logic            release_now;
  logic            tmo_only;

  rr_pick #(
    .NUMW (NUMW),
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .found  (found)
  );

  // gnt_num doubles as the owner index while a grant is held.
  assign owner_req   = req[gnt_num];
  assign hold_hit    = TMO_EN && (hold_cnt == HOLD_LAST);
  assign release_now = done || !owner_req || !ena || hold_hit;
  assign tmo_only    = hold_hit && !done && owner_req && ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= '1;
      gnt      <= '0;
      gnt_num  <= '0;
      gnt_vld  <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo <= 1'b0;
          if (ena && found) begin
            gnt      <= NREQ'(1) << winner;
            gnt_num  <= winner;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt     <= '0;
            gnt_num <= '0;
            gnt_vld <= 1'b0;
            tmo     <= tmo_only;
            last    <= gnt_num;
            state   <= IDLE;
          end else begin
            tmo <= 1'b0;
            if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_vld    : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == (|gnt));
  a_num    : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld || (gnt_num == '0));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NUMW=2, NREQ=4, HOLDMAX=4).
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_num;
  logic       gnt_vld;
  logic       tmo;

  int testCount = 0;
  int failCount = 0;

  rr_arbiter #(
    .NUMW    (2),
    .NREQ    (4),
    .HOLDW   (8),
    .HOLDMAX (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_num (gnt_num),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] g, input logic [1:0] n,
                            input logic v, input logic t);
    checkOutput({tag, ".gnt"}, 16'(gnt), 16'(g));
    checkOutput({tag, ".num"}, 16'(gnt_num), 16'(n));
    checkOutput({tag, ".vld"}, 16'(gnt_vld), 16'(v));
    checkOutput({tag, ".tmo"}, 16'(tmo), 16'(t));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic e, input logic d);
    req  = r;
    ena  = e;
    done = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checkState("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // All requesting, done pulsed in each grant: 0,1,2,3,0 with one idle gap each
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkState($sformatf("rr%0d", k), 4'(1 << seq[k]), 2'(seq[k]), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      checkState($sformatf("rr%0d_gap", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
    end

    // Single requester without done: four grant cycles, timeout pulse, re-grant
    applyStimulus(4'b0100, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkState($sformatf("hold%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    checkState("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    checkState("regrant2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Owner 1 loses its request; pointer at 1 sends next grants to 3 then 0
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    checkState("drop2", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    tick();
    checkState("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b1, 1'b0);
    tick();
    checkState("reqchg", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkState("next3", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    checkState("rel3", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    checkState("next0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // ena dropped while owner 2 holds: revoke without tmo, no grant while disabled
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick();
    tick();
    checkState("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    ena = 1'b0;
    tick();
    checkState("ena_off", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkState("ena_block", 4'b0000, 2'd0, 1'b0, 1'b0);
    ena = 1'b1;
    tick();
    checkState("ena_on", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Asynchronous reset while owner 3 holds; pointer returns so 1 wins over 3
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick();
    tick();
    checkState("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkState("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    checkState("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

    // done coincides with the timeout cycle: done wins, no tmo
    for (int k = 1; k < 4; k++) begin
      tick();
      checkState($sformatf("dhold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick();
    checkState("done_tmo", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;

    // No requests while idle leaves the pointer at 1, so all-request goes to 2
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    tick();
    checkState("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    tick();
    checkState("ptr_kept", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
